// File: rtl/fp_mult_seq.sv
// fp_mult_seq: parametrised sequential IEEE-754 multiplier.
// It uses a radix-2 shift-add significand datapath and supports four rounding modes and subnormals.
module fp_mult_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           rm,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 busy,
  output logic                 done,
  output logic                 invalid,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 inexact
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int P  = 2 * (MAN_W + 1);
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(MAN_W + 2);
  localparam int LW = $clog2(P);
  localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic [CW-1:0] LAST = CW'(MAN_W);

  typedef enum logic [2:0] {IDLE, CLASSIFY, MULT, NORM, ROUND, DONE} state_t;

  state_t         state_q;
  logic [W-1:0]   a_q, b_q, spc_q;
  logic [1:0]     rm_q;
  logic           sign_q, spec_q, inv_q, stk_q;
  logic [EW-1:0]  exp_q;
  logic [P-1:0]   acc_q;
  logic [MAN_W:0] mcand_q;
  logic [CW-1:0]  cnt_q;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic             sign_d, nan_d, spec_d;
  logic [EW-1:0]    exp_d;
  logic [W-1:0]     spc_d;

  assign ea     = a_q[W-2:MAN_W];
  assign eb     = b_q[W-2:MAN_W];
  assign fa     = a_q[MAN_W-1:0];
  assign fb     = b_q[MAN_W-1:0];
  assign a_nan  = &ea & |fa;
  assign b_nan  = &eb & |fb;
  assign a_inf  = &ea & ~|fa;
  assign b_inf  = &eb & ~|fb;
  assign a_zero = ~|ea & ~|fa;
  assign b_zero = ~|eb & ~|fb;
  assign sign_d = a_q[W-1] ^ b_q[W-1];
  assign nan_d  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
  assign spec_d = nan_d | a_inf | b_inf | a_zero | b_zero;
  // Subnormals share the exponent of the smallest normal (biased 1).
  assign exp_d  = {2'b00, ea[EXP_W-1:1], ea[0] | ~|ea} + {2'b00, eb[EXP_W-1:1], eb[0] | ~|eb} - BIAS;
  assign spc_d  = nan_d ? {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}} :
                  (a_inf | b_inf) ? {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {sign_d, {(W-1){1'b0}}};

  logic [MAN_W+1:0] psum;
  assign psum = {1'b0, acc_q[P-1:MAN_W+1]} + {1'b0, acc_q[0] ? mcand_q : '0};

  logic [LW-1:0] lz;
  logic [EW-1:0] expn, sh;
  logic [P-1:0]  nrm;
  logic          tiny;
  always_comb begin
    lz = '0;
    for (int i = 0; i < P; i++) lz = acc_q[i] ? LW'(P - 1 - i) : lz;
  end
  // Leading one lands at bit P-1, so a product in [2,4) needs no shift and gains +1.
  assign expn = exp_q + EW'(1) - EW'(lz);
  assign tiny = expn[EW-1] | ~|expn;
  assign sh   = EW'(1) - expn;
  assign nrm  = acc_q << lz;

  logic             g, r, s, grs, inc, ovf, big;
  logic [MAN_W+1:0] rsum;
  logic [EW-1:0]    expr;
  logic [W-1:0]     res_d;
  assign g     = acc_q[MAN_W];
  assign r     = acc_q[MAN_W-1];
  assign s     = |acc_q[MAN_W-2:0] | stk_q;
  assign grs   = g | r | s;
  assign inc   = rm_q == 2'b00 ? g & (r | s | acc_q[MAN_W+1]) :
                 rm_q == 2'b01 ? 1'b0 : rm_q == 2'b10 ? ~sign_q & grs : sign_q & grs;
  assign rsum  = {1'b0, acc_q[P-1:MAN_W+1]} + {{(MAN_W+1){1'b0}}, inc};
  // A carry-out leaves the fraction all-zero, so only the exponent needs fixing.
  assign expr  = ~|exp_q ? {{(EW-1){1'b0}}, rsum[MAN_W]} : exp_q + {{(EW-1){1'b0}}, rsum[MAN_W+1]};
  assign ovf   = expr >= EMAX;
  assign big   = rm_q == 2'b00 | (rm_q[1] & (rm_q[0] == sign_q));
  assign res_d = ~ovf ? {sign_q, expr[EXP_W-1:0], rsum[MAN_W-1:0]} :
                 big ? {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                 {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      spc_q     <= '0;
      rm_q      <= '0;
      sign_q    <= 1'b0;
      spec_q    <= 1'b0;
      inv_q     <= 1'b0;
      stk_q     <= 1'b0;
      exp_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      result    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      invalid   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q     <= a;
          b_q     <= b;
          rm_q    <= rm;
          busy    <= 1'b1;
          state_q <= CLASSIFY;
        end
        CLASSIFY: begin
          sign_q  <= sign_d;
          exp_q   <= exp_d;
          spec_q  <= spec_d;
          inv_q   <= nan_d;
          spc_q   <= spc_d;
          mcand_q <= {|ea, fa};
          acc_q   <= {{(MAN_W+1){1'b0}}, |eb, fb};
          cnt_q   <= '0;
          stk_q   <= 1'b0;
          state_q <= spec_d ? ROUND : MULT;
        end
        MULT: begin
          acc_q   <= {psum, acc_q[MAN_W:1]};
          cnt_q   <= cnt_q + CW'(1);
          state_q <= cnt_q == LAST ? NORM : MULT;
        end
        NORM: begin
          acc_q   <= tiny ? nrm >> sh : nrm;
          stk_q   <= tiny & |(nrm & ~({P{1'b1}} << sh));
          exp_q   <= tiny ? '0 : expn;
          state_q <= ROUND;
        end
        ROUND: begin
          result    <= spec_q ? spc_q : res_d;
          invalid   <= spec_q & inv_q;
          overflow  <= ~spec_q & ovf;
          underflow <= ~spec_q & ~|exp_q & grs;
          inexact   <= ~spec_q & (grs | ovf);
          done      <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_mult_seq.sv
// tb_fp_mult_seq: directed vectors for single- and half-precision instances of fp_mult_seq.
module tb_fp_mult_seq;
  logic        clk = 1'b0, rst = 1'b0;
  logic        start_s = 1'b0, start_h = 1'b0;
  logic [1:0]  rm_s = '0, rm_h = '0;
  logic [31:0] a_s = '0, b_s = '0, res_s;
  logic [15:0] a_h = '0, b_h = '0, res_h;
  logic        busy_s, done_s, inv_s, ovf_s, unf_s, inx_s;
  logic        busy_h, done_h, inv_h, ovf_h, unf_h, inx_h;
  int          checks = 0, failures = 0;
  bit          sel = 1'b0;
  logic        done_m, busy_m;
  logic [31:0] res_m;
  logic [3:0]  flg_m;

  always #5 clk = ~clk;

  fp_mult_seq u_sp (
    .clk(clk), .rst(rst), .start(start_s), .rm(rm_s), .a(a_s), .b(b_s), .result(res_s),
    .busy(busy_s), .done(done_s), .invalid(inv_s), .overflow(ovf_s), .underflow(unf_s), .inexact(inx_s)
  );

  fp_mult_seq #(.EXP_W(5), .MAN_W(10)) u_hp (
    .clk(clk), .rst(rst), .start(start_h), .rm(rm_h), .a(a_h), .b(b_h), .result(res_h),
    .busy(busy_h), .done(done_h), .invalid(inv_h), .overflow(ovf_h), .underflow(unf_h), .inexact(inx_h)
  );

  assign done_m = sel ? done_h : done_s;
  assign busy_m = sel ? busy_h : busy_s;
  assign res_m  = sel ? {16'h0, res_h} : res_s;
  assign flg_m  = sel ? {inv_h, ovf_h, unf_h, inx_h} : {inv_s, ovf_s, unf_s, inx_s};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ef = {invalid, overflow, underflow, inexact}; lat = edges from start edge to done cycle
  task automatic op(input string tag, input bit hp, input logic [31:0] x, input logic [31:0] y,
                    input logic [1:0] m, input logic [31:0] er, input logic [3:0] ef, input int lat,
                    input bit poke);
    int n = 0;
    sel = hp;
    @(negedge clk);
    if (hp) begin
      a_h = x[15:0]; b_h = y[15:0]; rm_h = m; start_h = 1'b1;
    end else begin
      a_s = x; b_s = y; rm_s = m; start_s = 1'b1;
    end
    @(negedge clk);
    start_s = 1'b0;
    start_h = 1'b0;
    check({tag, ":busy"}, {31'b0, busy_m}, 32'd1);
    while (!done_m && n < 100) begin
      @(negedge clk);
      n++;
      if (poke && n == 5) begin
        a_s = 32'h7F800001; start_s = 1'b1;
      end else start_s = 1'b0;
    end
    check({tag, ":lat"}, n, lat);
    check({tag, ":res"}, res_m, er);
    check({tag, ":flags"}, {28'b0, flg_m}, {28'b0, ef});
    @(negedge clk);
    check({tag, ":idle"}, {30'b0, busy_m, done_m}, 32'd0);
    if (poke) begin
      int d = 0;
      repeat (40) begin
        @(negedge clk);
        d += int'(done_m);
      end
      check({tag, ":extra_done"}, d, 0);
    end
    check({tag, ":hold"}, {res_m[27:0], flg_m}, {er[27:0], ef});
  endtask

  initial begin
    int seen = 0;
    #1;
    check("rst_res", res_s, 32'h0);
    check("rst_out", {26'b0, busy_s, done_s, inv_s, ovf_s, unf_s, inx_s}, 32'h0);
    check("rst_hp", {10'b0, res_h, busy_h, done_h, inv_h, ovf_h, unf_h, inx_h}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    op("mul3x2",    0, 32'h40400000, 32'h40000000, 2'd0, 32'h40C00000, 4'b0000, 27, 1);
    op("nan",       0, 32'h7F800001, 32'h3F800000, 2'd0, 32'h7FC00000, 4'b1000, 2, 0);
    op("inf_x0",    0, 32'h7F800000, 32'h00000000, 2'd0, 32'h7FC00000, 4'b1000, 2, 0);
    op("ninf",      0, 32'hFF800000, 32'h40000000, 2'd0, 32'hFF800000, 4'b0000, 2, 0);
    op("nzero",     0, 32'h80000000, 32'h3F800000, 2'd0, 32'h80000000, 4'b0000, 2, 0);
    op("ovf_rne",   0, 32'h7F7FFFFF, 32'h40000000, 2'd0, 32'h7F800000, 4'b0101, 27, 0);

    sel = 1'b0;
    @(negedge clk);
    a_s = 32'h40400000; b_s = 32'h40000000; rm_s = 2'd0; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_res", res_s, 32'h0);
    check("abort_out", {26'b0, busy_s, done_s, inv_s, ovf_s, unf_s, inx_s}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (30) begin
      @(negedge clk);
      seen += int'(done_s);
    end
    check("abort_nodone", seen, 0);

    op("ovf_rtz",   0, 32'h7F7FFFFF, 32'h40000000, 2'd1, 32'h7F7FFFFF, 4'b0101, 27, 0);
    op("ovf_rup_n", 0, 32'hFF7FFFFF, 32'h40000000, 2'd2, 32'hFF7FFFFF, 4'b0101, 27, 0);
    op("ulp_rne",   0, 32'h3F800001, 32'h3F800001, 2'd0, 32'h3F800002, 4'b0001, 27, 0);
    op("ulp_rup",   0, 32'h3F800001, 32'h3F800001, 2'd2, 32'h3F800003, 4'b0001, 27, 0);
    op("ulp_rtz",   0, 32'h3F800001, 32'h3F800001, 2'd1, 32'h3F800002, 4'b0001, 27, 0);
    op("ulp_rdn_n", 0, 32'hBF800001, 32'h3F800001, 2'd3, 32'hBF800003, 4'b0001, 27, 0);
    op("sub_half",  0, 32'h00800000, 32'h3F000000, 2'd0, 32'h00400000, 4'b0000, 27, 0);
    op("tiny_rne",  0, 32'h00000001, 32'h3F000000, 2'd0, 32'h00000000, 4'b0011, 27, 0);
    op("tiny_rup",  0, 32'h00000001, 32'h3F000000, 2'd2, 32'h00000001, 4'b0011, 27, 0);
    op("sub_x2",    0, 32'h00400000, 32'h40000000, 2'd0, 32'h00800000, 4'b0000, 27, 0);
    op("sub_x4",    0, 32'h00400000, 32'h40800000, 2'd0, 32'h01000000, 4'b0000, 27, 0);
    op("hp_one",    1, 32'h00003C00, 32'h00003C00, 2'd0, 32'h00003C00, 4'b0000, 14, 0);
    op("hp_ovf",    1, 32'h00007BFF, 32'h00004000, 2'd0, 32'h00007C00, 4'b0101, 14, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
